// File: rtl/core_decode_queue.sv
// Decode stage: fetch words are decoded at enqueue and held in a DEPTH-entry circular queue.
// Optional macro CORE_MEXT_EN enables decoding of the M extension (OP with funct7=0000001).

package core_pkg;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {SRC_RR, SRC_RI, SRC_ZI, SRC_PI} exec_src_e;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000, ALU_SRA = 4'b1101
  } alu_op_e;
  typedef enum logic [1:0] {MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU} mul_op_e;
  typedef enum logic [1:0] {ENG_ALU, ENG_MUL, ENG_DIV} exec_engine_e;
  typedef enum logic [1:0] {WB_NONE, WB_EXEC, WB_MEM, WB_FETCH} wb_src_e;
  typedef enum logic [1:0] {PC_NORMAL, PC_JUMP, PC_BRANCH} pc_src_e;
  typedef enum logic [2:0] {
    BR_EQ = 3'b000, BR_NE = 3'b001, BR_LT = 3'b100, BR_GE = 3'b101, BR_LTU = 3'b110, BR_GEU = 3'b111
  } br_type_e;
  typedef enum logic {MEM_READ, MEM_WRITE} mem_dir_e;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} mem_size_e;

  typedef struct packed {
    imm_type_e    imm_type;
    exec_src_e    exec_src;
    alu_op_e      alu_op;
    mul_op_e      mul_op;
    exec_engine_e exec_engine;
    wb_src_e      wb_src;
    pc_src_e      pc_src;
    br_type_e     br_type;
    mem_dir_e     mem_dir;
    mem_size_e    mem_size;
    logic         mem_op;
    logic         ecall;
    logic         illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    imm_type: IMM_I, exec_src: SRC_RR, alu_op: ALU_ADD, mul_op: MUL_LO,
    exec_engine: ENG_ALU, wb_src: WB_NONE, pc_src: PC_NORMAL, br_type: BR_EQ,
    mem_dir: MEM_READ, mem_size: SIZE_B, mem_op: 1'b0, ecall: 1'b0, illegal: 1'b0
  };

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

module core_decode_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [31:0]                out_instr,
  output imm_type_e                  out_imm_type,
  output exec_src_e                  out_exec_src,
  output alu_op_e                    out_alu_op,
  output mul_op_e                    out_mul_op,
  output exec_engine_e               out_exec_engine,
  output wb_src_e                    out_wb_src,
  output pc_src_e                    out_pc_src,
  output br_type_e                   out_br_type,
  output mem_dir_e                   out_mem_dir,
  output mem_size_e                  out_mem_size,
  output logic                       out_mem_op,
  output logic                       out_ecall,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctrl_t      dec;
  logic       bad;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    dec = CTRL_DEFAULT;
    bad = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.exec_src = SRC_RR;
        dec.wb_src   = WB_EXEC;
        dec.alu_op   = alu_op_e'({in_instr[30], funct3});
        if (funct7 == 7'b0000000) begin
          bad = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          bad = !(funct3 == 3'b000 || funct3 == 3'b101);
        end else if (funct7 == 7'b0000001) begin
`ifdef CORE_MEXT_EN
          dec.exec_engine = funct3[2] ? ENG_DIV : ENG_MUL;
          dec.mul_op      = mul_op_e'(funct3[1:0]);
`else
          bad = 1'b1;
`endif
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        dec.exec_src = SRC_RI;
        dec.wb_src   = WB_EXEC;
        if (funct3 == 3'b001) begin
          dec.alu_op = alu_op_e'({in_instr[30], funct3});
          bad        = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          dec.alu_op = alu_op_e'({in_instr[30], funct3});
          bad        = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
        end else begin
          dec.alu_op = alu_op_e'({1'b0, funct3});
        end
      end
      OPC_LUI: begin
        dec.imm_type = IMM_U;
        dec.exec_src = SRC_ZI;
        dec.wb_src   = WB_EXEC;
      end
      OPC_AUIPC: begin
        dec.imm_type = IMM_U;
        dec.exec_src = SRC_PI;
        dec.wb_src   = WB_EXEC;
      end
      OPC_JAL: begin
        dec.imm_type = IMM_J;
        dec.exec_src = SRC_PI;
        dec.wb_src   = WB_FETCH;
        dec.pc_src   = PC_JUMP;
      end
      OPC_JALR: begin
        dec.exec_src = SRC_RI;
        dec.wb_src   = WB_FETCH;
        dec.pc_src   = PC_JUMP;
        bad          = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        // Comparison is done by the ALU: equality via SUB, ordering via SLT/SLTU.
        dec.imm_type = IMM_B;
        dec.exec_src = SRC_RR;
        dec.pc_src   = PC_BRANCH;
        dec.br_type  = br_type_e'(funct3);
        case (funct3[2:1])
          2'b00:   dec.alu_op = ALU_SUB;
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.mem_op   = 1'b1;
        dec.mem_dir  = MEM_READ;
        dec.mem_size = mem_size_e'(funct3[1:0]);
        dec.wb_src   = WB_MEM;
      end
      OPC_STORE: begin
        dec.imm_type = IMM_S;
        dec.mem_op   = 1'b1;
        dec.mem_dir  = MEM_WRITE;
        dec.mem_size = mem_size_e'(funct3[1:0]);
      end
      OPC_SYSTEM: begin
        bad       = (in_instr[31:7] != 25'd0);
        dec.ecall = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = CTRL_DEFAULT;
      dec.illegal = 1'b1;
    end
  end

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push, pop;

  ctrl_t            ctrl_mem  [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  assign in_ready  = (count_reg < DEPTH_C) && !flush;
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_reg;

  // Storage carries no reset; only the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_mem[tail_reg]  <= dec;
      pc_mem[tail_reg]    <= in_pc;
      instr_mem[tail_reg] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= (tail_reg == LAST_C) ? '0 : tail_reg + 1'b1;
      if (pop)  head_reg <= (head_reg == LAST_C) ? '0 : head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  ctrl_t head_ctrl;
  assign head_ctrl       = ctrl_mem[head_reg];
  assign out_pc          = pc_mem[head_reg];
  assign out_instr       = instr_mem[head_reg];
  assign out_imm_type    = head_ctrl.imm_type;
  assign out_exec_src    = head_ctrl.exec_src;
  assign out_alu_op      = head_ctrl.alu_op;
  assign out_mul_op      = head_ctrl.mul_op;
  assign out_exec_engine = head_ctrl.exec_engine;
  assign out_wb_src      = head_ctrl.wb_src;
  assign out_pc_src      = head_ctrl.pc_src;
  assign out_br_type     = head_ctrl.br_type;
  assign out_mem_dir     = head_ctrl.mem_dir;
  assign out_mem_size    = head_ctrl.mem_size;
  assign out_mem_op      = head_ctrl.mem_op;
  assign out_ecall       = head_ctrl.ecall;
  assign out_illegal     = head_ctrl.illegal;

endmodule

// File: tb/tb_core_decode_queue.sv
// Bench for core_decode_queue: directed steps plus random traffic against a queue-based reference.
// Expectations follow CORE_MEXT_EN when the macro is defined for the build.
module tb_core_decode_queue;
  import core_pkg::*;

  localparam int DEPTH = 3;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef CORE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr, out_instr;
  logic [PC_W-1:0]  in_pc, out_pc;
  imm_type_e        out_imm_type;
  exec_src_e        out_exec_src;
  alu_op_e          out_alu_op;
  mul_op_e          out_mul_op;
  exec_engine_e     out_exec_engine;
  wb_src_e          out_wb_src;
  pc_src_e          out_pc_src;
  br_type_e         out_br_type;
  mem_dir_e         out_mem_dir;
  mem_size_e        out_mem_size;
  logic             out_mem_op, out_ecall, out_illegal;
  logic [CNT_W-1:0] count;

  core_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_imm_type(out_imm_type), .out_exec_src(out_exec_src), .out_alu_op(out_alu_op),
    .out_mul_op(out_mul_op), .out_exec_engine(out_exec_engine), .out_wb_src(out_wb_src),
    .out_pc_src(out_pc_src), .out_br_type(out_br_type), .out_mem_dir(out_mem_dir),
    .out_mem_size(out_mem_size), .out_mem_op(out_mem_op), .out_ecall(out_ecall),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    imm_type_e imm; exec_src_e src; alu_op_e alu; mul_op_e mul; exec_engine_e eng;
    wb_src_e wb; pc_src_e pcs; br_type_e br; mem_dir_e dir; mem_size_e size;
    logic mem_op; logic ecall; logic illegal;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Legality first, then the per-opcode row; anything illegal keeps the default row.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [6:0] opc = w[6:0];
    logic [2:0] f3  = w[14:12];
    logic [6:0] f7  = w[31:25];
    bit legal;
    e = '{IMM_I, SRC_RR, ALU_ADD, MUL_LO, ENG_ALU, WB_NONE, PC_NORMAL, BR_EQ,
          MEM_READ, SIZE_B, 1'b0, 1'b0, 1'b0};
    case (opc)
      7'h33: legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                     (MEXT && f7 == 7'h01);
      7'h13: legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                     (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      7'h37, 7'h17, 7'h6F, 7'h03, 7'h23: legal = 1'b1;
      7'h67: legal = (f3 == 3'd0);
      7'h63: legal = !(f3 == 3'd2 || f3 == 3'd3);
      7'h73: legal = (w[31:7] == 25'd0);
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.illegal = 1'b1;
      return e;
    end
    case (opc)
      7'h33: begin
        e.src = SRC_RR; e.wb = WB_EXEC;
        if (f7 == 7'h01) begin
          e.alu = alu_op_e'({1'b0, f3});
          e.eng = (f3 >= 3'd4) ? ENG_DIV : ENG_MUL;
          e.mul = mul_op_e'(f3 % 4);
        end else begin
          e.alu = alu_op_e'({f7 == 7'h20, f3});
        end
      end
      7'h13: begin
        e.src = SRC_RI; e.wb = WB_EXEC;
        e.alu = alu_op_e'({(f3 == 3'd5) && (f7 == 7'h20), f3});
      end
      7'h37: begin e.imm = IMM_U; e.src = SRC_ZI; e.wb = WB_EXEC; end
      7'h17: begin e.imm = IMM_U; e.src = SRC_PI; e.wb = WB_EXEC; end
      7'h6F: begin e.imm = IMM_J; e.src = SRC_PI; e.wb = WB_FETCH; e.pcs = PC_JUMP; end
      7'h67: begin e.src = SRC_RI; e.wb = WB_FETCH; e.pcs = PC_JUMP; end
      7'h63: begin
        e.imm = IMM_B; e.pcs = PC_BRANCH; e.br = br_type_e'(f3);
        e.alu = (f3 < 3'd4) ? ALU_SUB : (f3 < 3'd6) ? ALU_SLT : ALU_SLTU;
      end
      7'h03: begin e.mem_op = 1'b1; e.dir = MEM_READ; e.wb = WB_MEM; e.size = mem_size_e'(f3 % 4); end
      7'h23: begin e.imm = IMM_S; e.mem_op = 1'b1; e.dir = MEM_WRITE; e.size = mem_size_e'(f3 % 4); end
      7'h73: e.ecall = 1'b1;
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[11] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h73, 7'h00};
    logic [6:0] f7s[4]   = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 10);
    if (k == 10) return w;
    w[6:0]   = opcs[k];
    w[31:25] = f7s[$urandom_range(0, 3)];
    if (opcs[k] == 7'h73 && $urandom_range(0, 1) == 0) w = 32'h0000_0073;
    return w;
  endfunction

  task automatic check_head();
    exp_t e = ref_decode(mq[0].instr);
    chk("out_pc", out_pc, mq[0].pc);
    chk("out_instr", out_instr, mq[0].instr);
    chk("imm_type", out_imm_type, e.imm);
    chk("exec_src", out_exec_src, e.src);
    chk("alu_op", out_alu_op, e.alu);
    chk("mul_op", out_mul_op, e.mul);
    chk("exec_engine", out_exec_engine, e.eng);
    chk("wb_src", out_wb_src, e.wb);
    chk("pc_src", out_pc_src, e.pcs);
    chk("br_type", out_br_type, e.br);
    chk("mem_dir", out_mem_dir, e.dir);
    chk("mem_size", out_mem_size, e.size);
    chk("mem_op", out_mem_op, e.mem_op);
    chk("ecall", out_ecall, e.ecall);
    chk("illegal", out_illegal, e.illegal);
  endtask

  // One clock: drive, check against the model, advance the model on the edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic [PC_W-1:0] p,
                       input logic ordy, input logic fl, output bit acc);
    bit exp_ready, do_pop;
    in_valid = v; in_instr = w; in_pc = p; out_ready = ordy; flush = fl;
    #1;
    exp_ready = (mq.size() < DEPTH) && !fl;
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    if (mq.size() != 0) check_head();
    acc    = v && exp_ready;
    do_pop = ordy && (mq.size() != 0);
    if (do_pop && !fl)
      $display("pop  pc=%h instr=%h illegal=%0b", mq[0].pc, mq[0].instr, ref_decode(mq[0].instr).illegal);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (acc) mq.push_back('{p, w});
    end
    @(negedge clk);
  endtask

  task automatic push_until(input logic [31:0] w, input logic [PC_W-1:0] p, input logic ordy);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc && guard < 20) begin
      cycle(1'b1, w, p, ordy, 1'b0, acc);
      guard++;
    end
    if (!acc) chk("push_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    while (mq.size() != 0 && guard < 4 * DEPTH) begin
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0, acc);
      guard++;
    end
    if (mq.size() != 0) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    bit acc;
    logic [31:0] ill[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h4231_00B3};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // ADD x1,x2,x3 at 0x100
    cycle(1'b1, 32'h0031_00B3, 32'h100, 1'b0, 1'b0, acc);
    #0;
    chk("add_alu", out_alu_op, ALU_ADD);
    chk("add_src", out_exec_src, SRC_RR);
    chk("add_wb", out_wb_src, WB_EXEC);
    drain();

    // Fill to DEPTH, offer one more while full, then pop to let it in.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0000_0013 + (i << 20), 32'h200 + 4 * i, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0050_0013, 32'h300, 1'b0, 1'b0, acc);
    chk("full_no_accept", acc, 1'b0);
    cycle(1'b1, 32'h0050_0013, 32'h300, 1'b1, 1'b0, acc);
    chk("pop_cycle_no_accept", acc, 1'b0);
    cycle(1'b1, 32'h0050_0013, 32'h300, 1'b0, 1'b0, acc);
    chk("accept_after_pop", acc, 1'b1);
    drain();

    // Streaming: occupancy holds at 1 while pointers wrap.
    push_until(32'h0000_0037, 32'h400, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(1'b1, 32'h0000_0017 + (i << 12), 32'h400 + 4 * i, 1'b1, 1'b0, acc);
    drain();

    // Illegal encodings and MUL
    for (int i = 0; i < 3; i++) push_until(ill[i], 32'h500 + 4 * i, 1'b0);
    drain();
    push_until(32'h0231_00B3, 32'h600, 1'b0);
    #0;
    chk("mul_illegal", out_illegal, !MEXT);
    chk("mul_engine", out_exec_engine, MEXT ? ENG_MUL : ENG_ALU);
    drain();

    // Flush with an offered word, then ECALL
    for (int i = 0; i < 3; i++) push_until(32'h0000_0033, 32'h700 + 4 * i, 1'b0);
    cycle(1'b1, 32'h0000_0013, 32'h710, 1'b0, 1'b1, acc);
    chk("flush_count", count, 0);
    push_until(32'h0000_0073, 32'h800, 1'b0);
    chk("ecall", out_ecall, 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 29) == 0, acc);
    drain();

    // Asynchronous reset mid-stream
    push_until(32'h0000_0033, 32'h900, 1'b0);
    push_until(32'h0000_0033, 32'h904, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", out_valid, 1'b0);
    mq.delete();
    @(posedge clk); #1;
    chk("rst_no_handshake", count, 0);
    @(negedge clk); rst = 1'b0;
    push_until(32'h0000_006F, 32'hA00, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_decode_queue.md
# core_decode_queue

Registered decode stage between fetch and execute. Instruction words from fetch enter through a valid/ready handshake and are decoded at enqueue into the core control bundle. Decoded entries are held in a DEPTH-entry circular queue, so fetch and execute are decoupled by one or more instructions. The block also flags illegal encodings, supports pipeline flush, and optionally decodes the M extension.

## Interface
Parameters:
- DEPTH, 2, queue entries; any integer ≥ 2, power of two not required
- PC_W, 32, width of the program counter carried with each entry

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued entries and the current input
- in_valid  input  1  fetch offers in_instr/in_pc
- in_ready  output  1  queue can accept this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head
- out_pc, out_instr  output  PC_W, 32  head PC and raw word
- out_imm_type, out_exec_src, out_alu_op, out_mul_op, out_exec_engine  output  core_pkg enums  head decode fields
- out_wb_src, out_pc_src, out_br_type, out_mem_dir, out_mem_size  output  core_pkg enums  head decode fields
- out_mem_op, out_ecall, out_illegal  output  1 each  head flags
- count  output  $clog2(DEPTH+1)  current occupancy

## Operation
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready.
- The decode is combinational on in_instr and written into the tail entry together with in_pc and in_instr.
- Decode rows, per opcode:
  - OP: imm I, src RR, wb EXEC
  - OPIMM: imm I, src RI, wb EXEC
  - LUI: imm U, src ZI, wb EXEC
  - AUIPC: imm U, src PI, wb EXEC
  - JAL: imm J, src PI, wb FETCH, pc JUMP
  - JALR: imm I, src RI, wb FETCH, pc JUMP
  - BRANCH: imm B, src RR, wb NONE, pc BRANCH
  - LOAD: mem_op=1, READ, wb MEM
  - STORE: imm S, mem_op=1, WRITE, wb NONE
- ALU op, branch type, mem_size and mul_op follow the core decode rules:
  - alu_op is {instr[30], funct3} for OP and for OPIMM shifts; otherwise {0, funct3}.
  - BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
  - Default alu_op is ADD.
- out_illegal=1 when any of the following holds:
  - instr[1:0] != 2'b11
  - the opcode is not one of the nine above and not SYSTEM
  - SYSTEM with instr[31:7] != 0
  - OP with funct7 ∉ {0000000, 0100000 (funct3 000/101 only), 0000001 (see Configuration)}
  - OPIMM shift with funct7 ∉ {0000000, 0100000 (SRAI only)}
  - BRANCH with funct3 010/011
  - JALR with funct3 != 000
- Illegal entries are still enqueued. Their controls are forced to the default row: src RR, wb NONE, pc NORMAL, mem_op=0, engine ALU, ecall=0.
- Head/tail pointers wrap from DEPTH-1 to 0.
- in_ready = (count < DEPTH) && !flush. There is no full-queue pass-through.
- out_valid = (count != 0). The out_* fields are meaningless while out_valid=0.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- flush high: on the next edge count=0 and both pointers return to 0. Any dequeue or enqueue in that cycle is void, and out_valid stays as computed from count in that cycle.

## Timing
- Reset (asynchronous): count=0, pointers=0, out_valid=0, in_ready=1. Queue storage is not reset.
- Latency: an entry accepted at edge N is visible at out_* after edge N; out_valid rises in cycle N+1.
- Throughput: one instruction per cycle in steady state.
- A full queue with out_ready=1 re-asserts in_ready the cycle after the pop.
- Reset asserted mid-stream clears all entries immediately. No handshake completes while rst is high.

## Configuration
- CORE_MEXT_EN defined: OP with funct7=0000001 is legal.
  - exec_engine = MUL when funct3[2]=0, DIV when funct3[2]=1.
  - mul_op = funct3[1:0].
- CORE_MEXT_EN undefined:
  - OP with funct7=0000001 is illegal.
  - exec_engine is always ALU; mul_op is driven 0.

## Test plan
- Reset, then enqueue ADD x1,x2,x3 (0x003100B3) at PC 0x100 → next cycle out_valid=1, out_pc=0x100, alu_op ADD, src RR, wb EXEC, out_illegal=0.
- DEPTH=4, out_ready=0, push 5 words → in_ready drops after the 4th accept, count=4. Pop once → in_ready=1 the next cycle and the 5th word is accepted. Entries emerge in order.
- Continuous push and pop with DEPTH=3 for 10 instructions → count stays at 1, no drops or duplicates, and pointers wrap correctly.
- Push 0xFFFFFFFF, 0x00000000 and SUB with funct7=0100001 → all three dequeue with out_illegal=1, wb NONE, mem_op=0.
- MUL x1,x2,x3 (0x023100B3) → with CORE_MEXT_EN: engine MUL, illegal=0. Without: illegal=1, engine ALU.
- Fill 3 entries, assert flush for one cycle with in_valid=1 → count=0 and no entry accepted in that cycle. Pushing 0x00000073 afterwards yields out_ecall=1.
